// File: rtl/pad_attr_ctrl_pkg.sv
// Shared types and default sizes for the DIO pad attribute controller.
package pad_attr_ctrl_pkg;

    localparam int unsigned NDioPadsDef = 24;
    localparam int unsigned AttrDwDef   = 32;
    localparam int unsigned IdxWDef     = $clog2(NDioPadsDef);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    typedef struct packed {
        logic                 we;
        logic [IdxWDef-1:0]   idx;
        logic [AttrDwDef-1:0] wdata;
    } attr_req_t;

endpackage

// File: rtl/pad_attr_rr_arb.sv
// Round-robin arbiter: picks the first request at or after the pointer, wrapping.
module pad_attr_rr_arb #(
    parameter  int unsigned NReq = 2,
    localparam int unsigned IdW  = (NReq > 1) ? $clog2(NReq) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NReq-1:0] req_i,
    input  logic            advance_i,
    output logic            valid_o,
    output logic [NReq-1:0] gnt_o,
    output logic [IdW-1:0]  idx_o
);

    logic [IdW-1:0] ptr_q;
    logic           found;
    logic [IdW-1:0] win;
    logic [IdW-1:0] cand;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NReq; i++) begin
            cand = IdW'((32'(ptr_q) + i) % NReq);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (found) gnt_o[win] = 1'b1;
    end

    assign valid_o = found;
    assign idx_o   = win;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (advance_i && found) begin
            ptr_q <= (win == IdW'(NReq - 1)) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/pad_attr_ctrl.sv
// Per-pad attribute registers with round-robin access from NReq requesters.
// Optional per-pad write lock enabled by PAD_ATTR_CTRL_LOCK_EN.
module pad_attr_ctrl
    import pad_attr_ctrl_pkg::*;
#(
    parameter  int unsigned NDioPads = NDioPadsDef,
    parameter  int unsigned AttrDw   = AttrDwDef,
    parameter  int unsigned NReq     = 2,
    localparam int unsigned IdxW     = $clog2(NDioPads),
    localparam int unsigned IdW      = (NReq > 1) ? $clog2(NReq) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [AttrDw-1:0]          supp_mask_i,
    input  logic [NReq-1:0]            req_i,
    input  logic [NReq-1:0]            we_i,
    input  logic [NReq*IdxW-1:0]       idx_i,
    input  logic [NReq*AttrDw-1:0]     wdata_i,
    output logic [NReq-1:0]            gnt_o,
    output logic                       rvalid_o,
    output logic [IdW-1:0]             rid_o,
    output logic [AttrDw-1:0]          rdata_o,
    output logic                       err_o,
    output logic [NDioPads*AttrDw-1:0] attr_o
);

    state_e             state_q;
    attr_req_t          req_q;
    logic [IdW-1:0]     id_q;
    logic [NReq-1:0]    gnt_q;
    logic               rvalid_q;
    logic [IdW-1:0]     rid_q;
    logic [AttrDw-1:0]  rdata_q;
    logic               err_q;
    logic [AttrDw-1:0]  res_data_q;
    logic               res_err_q;
    logic               wr_pend_q;
    logic [AttrDw-1:0]  attr_q [NDioPads];

    logic               arb_valid;
    logic [NReq-1:0]    arb_gnt;
    logic [IdW-1:0]     arb_idx;
    logic               in_range;
    logic               locked;

    pad_attr_rr_arb #(
        .NReq (NReq)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .advance_i (state_q == IDLE),
        .valid_o   (arb_valid),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx)
    );

    assign in_range = (32'(req_q.idx) < NDioPads);

`ifdef PAD_ATTR_CTRL_LOCK_EN
    logic lock_q [NDioPads];
    assign locked = lock_q[req_q.idx];
`else
    assign locked = 1'b0;
`endif

    // Result is computed in EXEC but committed with rvalid in RESP, so
    // rdata/err hold until the response and attr_o updates at N+2.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            req_q      <= '0;
            id_q       <= '0;
            gnt_q      <= '0;
            rvalid_q   <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            wr_pend_q  <= 1'b0;
            for (int unsigned k = 0; k < NDioPads; k++) begin
                attr_q[k] <= '0;
`ifdef PAD_ATTR_CTRL_LOCK_EN
                lock_q[k] <= 1'b0;
`endif
            end
        end else begin
            gnt_q    <= '0;
            rvalid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        gnt_q       <= arb_gnt;
                        id_q        <= arb_idx;
                        req_q.we    <= we_i[arb_idx];
                        req_q.idx   <= idx_i[arb_idx*IdxW +: IdxW];
                        req_q.wdata <= wdata_i[arb_idx*AttrDw +: AttrDw];
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    res_err_q  <= 1'b0;
                    res_data_q <= '0;
                    wr_pend_q  <= 1'b0;
                    if (!in_range) begin
                        res_err_q <= 1'b1;
                    end else if (!req_q.we) begin
                        res_data_q <= attr_q[req_q.idx];
                    end else if (locked) begin
                        res_err_q  <= 1'b1;
                        res_data_q <= attr_q[req_q.idx];
                    end else begin
                        res_data_q <= req_q.wdata & supp_mask_i;
                        wr_pend_q  <= 1'b1;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    rvalid_q <= 1'b1;
                    rid_q    <= id_q;
                    rdata_q  <= res_data_q;
                    err_q    <= res_err_q;
                    if (wr_pend_q) begin
                        attr_q[req_q.idx] <= res_data_q;
`ifdef PAD_ATTR_CTRL_LOCK_EN
                        if (req_q.wdata[AttrDw-1]) lock_q[req_q.idx] <= 1'b1;
`endif
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NDioPads; k++) begin : g_attr
        assign attr_o[k*AttrDw +: AttrDw] = attr_q[k];
    end

    assign gnt_o    = gnt_q;
    assign rvalid_o = rvalid_q;
    assign rid_o    = rid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_pad_attr_ctrl.sv
// Directed self-checking bench for pad_attr_ctrl (default config, 2 requesters).
module tb_pad_attr_ctrl;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic [31:0]  supp_mask;
    logic [1:0]   req;
    logic [1:0]   we;
    logic [9:0]   idx;
    logic [63:0]  wdata;
    logic [1:0]   gnt;
    logic         rvalid;
    logic [0:0]   rid;
    logic [31:0]  rdata;
    logic         err;
    logic [767:0] attr;
    logic [767:0] exp_attr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pad_attr_ctrl #(
        .NDioPads (24),
        .AttrDw   (32),
        .NReq     (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .supp_mask_i (supp_mask),
        .req_i       (req),
        .we_i        (we),
        .idx_i       (idx),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rid_o       (rid),
        .rdata_o     (rdata),
        .err_o       (err),
        .attr_o      (attr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_attr(input string tag);
        n_chk++;
        assert (attr === exp_attr) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, attr, exp_attr);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string tag);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (gnt != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_gnt_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic txn(input string tag, input int r, input logic w, input logic [4:0] ix,
                       input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
        req           = 2'b00;
        req[r]        = 1'b1;
        we[r]         = w;
        idx[r*5 +: 5] = ix;
        wdata[r*32 +: 32] = wd;
        wait_gnt(tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'(1 << r));
        req = 2'b00;
        step();
        chk({tag, "_rv_early"}, 32'(rvalid), 32'd0);
        step();
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        chk({tag, "_rid"}, 32'(rid), 32'(r));
        chk({tag, "_rdata"}, rdata, exp_d);
        chk({tag, "_err"}, 32'(err), 32'(exp_e));
        chk_attr({tag, "_attr"});
        step();
        chk({tag, "_rv_pulse"}, 32'(rvalid), 32'd0);
    endtask

    initial begin
        rst_ni    = 1'b0;
        supp_mask = 32'h0;
        req       = 2'b00;
        we        = 2'b00;
        idx       = '0;
        wdata     = '0;
        exp_attr  = '0;
        repeat (3) step();

        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rid", 32'(rid), 32'd0);
        chk_attr("rst_attr");
        rst_ni = 1'b1;

        // masked write to pad 3, then read it back from the other requester
        supp_mask = 32'h0000_0001;
        exp_attr[96 +: 32] = 32'h1;
        txn("wr3", 0, 1'b1, 5'd3, 32'hFFFF_FFFF, 32'h1, 1'b0);
        txn("rd3", 1, 1'b0, 5'd3, 32'h0, 32'h1, 1'b0);

        txn("wr24", 0, 1'b1, 5'd24, 32'h5, 32'h0, 1'b1);

        supp_mask = 32'hFFFF_FFFF;
        exp_attr[0 +: 32] = 32'h1234_5678;
        txn("wr0", 1, 1'b1, 5'd0, 32'h1234_5678, 32'h1234_5678, 1'b0);
        chk("hold_rdata", rdata, 32'h1234_5678);
        chk("hold_err", 32'(err), 32'd0);

        // narrowing the mask does not touch stored words; pad 23 is the top valid index
        supp_mask = 32'h0000_FFFF;
        txn("rd0", 0, 1'b0, 5'd0, 32'h0, 32'h1234_5678, 1'b0);
        exp_attr[736 +: 32] = 32'h0000_1234;
        txn("wr23", 1, 1'b1, 5'd23, 32'hABCD_1234, 32'h0000_1234, 1'b0);

        // both requesting: last winner was 1, so grants go 01,10,01,...
        we  = 2'b00;
        idx = {5'd3, 5'd3};
        req = 2'b11;
        for (int g = 0; g < 6; g++) begin
            wait_gnt("rr");
            chk("rr_seq", 32'(gnt), (g % 2 == 0) ? 32'd1 : 32'd2);
        end
        req = 2'b00;
        repeat (3) step();

        // reset during EXEC aborts the write and suppresses the response
        supp_mask = 32'hFFFF_FFFF;
        req   = 2'b01;
        we    = 2'b01;
        idx[4:0]    = 5'd7;
        wdata[31:0] = 32'hFFFF_FFFF;
        wait_gnt("abort");
        req    = 2'b00;
        rst_ni = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("abort_rvalid", 32'(rvalid), 32'd0);
        end
        exp_attr = '0;
        chk_attr("abort_attr");
        rst_ni = 1'b1;

`ifdef PAD_ATTR_CTRL_LOCK_EN
        exp_attr[160 +: 32] = 32'h8000_0001;
        txn("lk_wr5", 0, 1'b1, 5'd5, 32'h8000_0001, 32'h8000_0001, 1'b0);
        txn("lk_wr5b", 1, 1'b1, 5'd5, 32'h0, 32'h8000_0001, 1'b1);
        txn("lk_rd5", 0, 1'b0, 5'd5, 32'h0, 32'h8000_0001, 1'b0);
`else
        supp_mask = 32'h7FFF_FFFF;
        exp_attr[160 +: 32] = 32'h0000_0001;
        txn("nl_wr5", 0, 1'b1, 5'd5, 32'h8000_0001, 32'h0000_0001, 1'b0);
        exp_attr[160 +: 32] = 32'h0;
        txn("nl_wr5b", 1, 1'b1, 5'd5, 32'h0, 32'h0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
